// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decodes the ID-stage opcode into a control bundle and carries
// it through ID/EX, EX/MEM and MEM/WB registers. Bubbles are all-zero bundles.
// Optional load-use hazard detection is compiled in with the macro
// PIPE_CTRL_HAZARD_DETECT_EN; without it, stall simply mirrors ext_stall.
module pipe_ctrl_unit #(
  parameter int ALU_OP_W   = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_illegal,
  output logic                  mem_branch,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_SLTI  = 6'd10;

  // decoded bundle for the ID instruction
  logic                dec_reg_dst, dec_alu_src, dec_branch, dec_mem_read;
  logic                dec_mem_write, dec_reg_write, dec_mem_to_reg, dec_illegal;
  logic [3:0]          dec_alu_op4;
  logic [ALU_OP_W-1:0] dec_alu_op;

  // pipeline state
  logic                ex_reg_dst_q, ex_alu_src_q, ex_branch_q, ex_mem_read_q;
  logic                ex_mem_write_q, ex_reg_write_q, ex_mem_to_reg_q, ex_illegal_q;
  logic [ALU_OP_W-1:0] ex_alu_op_q;
  logic                ex_reg_dst_d, ex_alu_src_d, ex_branch_d, ex_mem_read_d;
  logic                ex_mem_write_d, ex_reg_write_d, ex_mem_to_reg_d, ex_illegal_d;
  logic [ALU_OP_W-1:0] ex_alu_op_d;
  logic                mem_branch_q, mem_read_q, mem_write_q, mem_reg_write_q, mem_to_reg_q;
  logic                mem_branch_d, mem_read_d, mem_write_d, mem_reg_write_d, mem_to_reg_d;
  logic                wb_reg_write_q, wb_mem_to_reg_q, wb_reg_write_d, wb_mem_to_reg_d;

  logic hazard;
  logic id_load;

  // opcode decode table; anything not listed becomes an all-zero illegal bundle
  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op4    = 4'b0000;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_illegal    = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin dec_reg_dst = 1'b1; dec_alu_op4 = 4'b0010; dec_reg_write = 1'b1; end
      OP_LW:    begin dec_alu_src = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
                      dec_mem_to_reg = 1'b1; end
      OP_SW:    begin dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      OP_BEQ:   begin dec_alu_op4 = 4'b0001; dec_branch = 1'b1; end
      OP_ADDI:  begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_ANDI:  begin dec_alu_src = 1'b1; dec_alu_op4 = 4'b0011; dec_reg_write = 1'b1; end
      OP_ORI:   begin dec_alu_src = 1'b1; dec_alu_op4 = 4'b0100; dec_reg_write = 1'b1; end
      OP_SLTI:  begin dec_alu_src = 1'b1; dec_alu_op4 = 4'b0101; dec_reg_write = 1'b1; end
      default:  dec_illegal = 1'b1;
    endcase
    dec_alu_op      = '0;
    dec_alu_op[3:0] = dec_alu_op4;
  end

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
  // destination of the instruction in EX, only needed for load-use detection
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic                  id_uses_rt;

  // load-use hazard: a load in EX writes a register the ID instruction reads
  always_comb begin
    id_uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || (id_opcode == OP_BEQ);
    hazard     = ex_mem_read_q && (ex_rt_q != '0) && id_valid &&
                 ((ex_rt_q == id_rs) || ((ex_rt_q == id_rt) && id_uses_rt));
    ex_rt_d    = id_load ? id_rt : '0;
  end

  // EX destination register
  always_ff @(posedge clk) begin
    if (!reset) ex_rt_q <= '0;
    else        ex_rt_q <= ex_rt_d;
  end
`else
  logic unused_src_specifiers;
  assign unused_src_specifiers = ^{id_rs, id_rt};
  assign hazard = 1'b0;
`endif

  assign stall   = ext_stall | hazard;
  assign id_load = id_valid & ~stall & ~flush;

  // next-state for all stages: bubbles are zero, flush kills EX on its way to MEM
  always_comb begin
    ex_reg_dst_d    = id_load & dec_reg_dst;
    ex_alu_src_d    = id_load & dec_alu_src;
    ex_alu_op_d     = id_load ? dec_alu_op : '0;
    ex_branch_d     = id_load & dec_branch;
    ex_mem_read_d   = id_load & dec_mem_read;
    ex_mem_write_d  = id_load & dec_mem_write;
    ex_reg_write_d  = id_load & dec_reg_write;
    ex_mem_to_reg_d = id_load & dec_mem_to_reg;
    ex_illegal_d    = id_load & dec_illegal;
    mem_branch_d    = ~flush & ex_branch_q;
    mem_read_d      = ~flush & ex_mem_read_q;
    mem_write_d     = ~flush & ex_mem_write_q;
    mem_reg_write_d = ~flush & ex_reg_write_q;
    mem_to_reg_d    = ~flush & ex_mem_to_reg_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_to_reg_d = mem_to_reg_q;
  end

  // pipeline registers; reset fills every stage with bubbles
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_reg_dst_q    <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_alu_op_q     <= '0;
      ex_branch_q     <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_illegal_q    <= 1'b0;
      mem_branch_q    <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end else begin
      ex_reg_dst_q    <= ex_reg_dst_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_branch_q     <= ex_branch_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_illegal_q    <= ex_illegal_d;
      mem_branch_q    <= mem_branch_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
    end
  end

  assign ex_reg_dst    = ex_reg_dst_q;
  assign ex_alu_src    = ex_alu_src_q;
  assign ex_alu_op     = ex_alu_op_q;
  assign ex_illegal    = ex_illegal_q;
  assign mem_branch    = mem_branch_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a bundle-level pipeline model.
// A second instance with ALU_OP_W=6 shares the inputs.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic [4:0] rt;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = 6'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       ext_stall = 1'b0;
  logic       flush = 1'b0;

  logic       stall, ex_reg_dst, ex_alu_src, ex_illegal;
  logic [3:0] ex_alu_op;
  logic       mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;

  logic       stall6, ex_reg_dst6, ex_alu_src6, ex_illegal6;
  logic [5:0] ex_alu_op6;
  logic       mem_branch6, mem_read6, mem_write6, wb_reg_write6, wb_mem_to_reg6;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;
  ctl_t m_ex = '0, m_mem = '0, m_wb = '0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.ALU_OP_W(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ext_stall(ext_stall), .flush(flush),
    .stall(stall), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal), .mem_branch(mem_branch),
    .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg));

  pipe_ctrl_unit #(.ALU_OP_W(6), .REG_ADDR_W(5)) dut6 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ext_stall(ext_stall), .flush(flush),
    .stall(stall6), .ex_reg_dst(ex_reg_dst6), .ex_alu_src(ex_alu_src6),
    .ex_alu_op(ex_alu_op6), .ex_illegal(ex_illegal6), .mem_branch(mem_branch6),
    .mem_read(mem_read6), .mem_write(mem_write6), .wb_reg_write(wb_reg_write6),
    .wb_mem_to_reg(wb_mem_to_reg6));

  // reference decode table
  function automatic ctl_t decode(input logic [5:0] op, input logic [4:0] rt);
    ctl_t c = '0;
    c.rt = rt;
    case (op)
      6'd0:  begin c.reg_dst = 1; c.alu_op = 4'd2; c.reg_write = 1; end
      6'd35: begin c.alu_src = 1; c.mem_read = 1; c.reg_write = 1; c.mem_to_reg = 1; end
      6'd43: begin c.alu_src = 1; c.mem_write = 1; end
      6'd4:  begin c.alu_op = 4'd1; c.branch = 1; end
      6'd8:  begin c.alu_src = 1; c.reg_write = 1; end
      6'd12: begin c.alu_src = 1; c.alu_op = 4'd3; c.reg_write = 1; end
      6'd13: begin c.alu_src = 1; c.alu_op = 4'd4; c.reg_write = 1; end
      6'd10: begin c.alu_src = 1; c.alu_op = 4'd5; c.reg_write = 1; end
      default: begin c = '0; c.illegal = 1; end
    endcase
    return c;
  endfunction

  // expected stall given the model's EX content and the current ID inputs
  function automatic logic model_stall();
    logic hz = 1'b0;
`ifdef PIPE_CTRL_HAZARD_DETECT_EN
    hz = m_ex.mem_read && (m_ex.rt != 0) && id_valid &&
         ((m_ex.rt == id_rs) ||
          ((m_ex.rt == id_rt) && (id_opcode == 6'd0 || id_opcode == 6'd43 || id_opcode == 6'd4)));
`endif
    return ext_stall | hz;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // model: one bundle per stage, advanced from the documented rules
  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0;
    end else begin
      m_ex  <= (id_valid && !model_stall() && !flush) ? decode(id_opcode, id_rt) : '0;
      m_mem <= flush ? '0 : m_ex;
      m_wb  <= m_mem;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (started) begin
      chk("stall", stall, model_stall());
      chk("ex_reg_dst", ex_reg_dst, m_ex.reg_dst);
      chk("ex_alu_src", ex_alu_src, m_ex.alu_src);
      chk("ex_alu_op", ex_alu_op, m_ex.alu_op);
      chk("ex_illegal", ex_illegal, m_ex.illegal);
      chk("mem_branch", mem_branch, m_mem.branch);
      chk("mem_read", mem_read, m_mem.mem_read);
      chk("mem_write", mem_write, m_mem.mem_write);
      chk("wb_reg_write", wb_reg_write, m_wb.reg_write);
      chk("wb_mem_to_reg", wb_mem_to_reg, m_wb.mem_to_reg);
      chk("ex_alu_op6", ex_alu_op6, {2'b00, m_ex.alu_op});
      chk("ex_alu_src6", ex_alu_src6, m_ex.alu_src);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic es, input logic fl);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; ext_stall = es; flush = fl;
  endtask

  task automatic idle();
    drive(0, 6'd0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {ex_reg_dst, ex_alu_src, ex_alu_op, ex_illegal, mem_branch, mem_read,
               mem_write, wb_reg_write, wb_mem_to_reg, stall}, 32'd0);
  endtask

  logic [5:0] seq_ops [8];
  logic [3:0] seq_alu [8];
  logic [5:0] rand_ops [10];

  initial begin
    seq_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd13, 6'd10};
    seq_alu = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0101};
    rand_ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd13, 6'd10, 6'd63, 6'd1};

    // reset held low with an LW presented
    reset = 1'b0;
    drive(1, 6'd35, 5'd1, 5'd7, 0, 0);
    tick(); tick();
    chk_all_zero("reset_all_zero");
    // release: LW flows EX -> MEM -> WB
    reset = 1'b1;
    tick();
    chk("lw_ex_alu_src", ex_alu_src, 1);
    idle();
    tick();
    chk("lw_mem_read", mem_read, 1);
    tick();
    chk("lw_wb_mem_to_reg", wb_mem_to_reg, 1);
    tick();

    // back-to-back decode of the whole opcode table
    for (int i = 0; i < 8; i++) begin
      drive(1, seq_ops[i], 5'd3, 5'd0, 0, 0);
      tick();
      chk($sformatf("seq_alu_op_%0d", i), ex_alu_op, seq_alu[i]);
    end
    idle(); tick(); tick(); tick();

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
    // load-use: LW rt=5 followed by R-type rs=5
    drive(1, 6'd35, 5'd1, 5'd5, 0, 0);
    tick();
    drive(1, 6'd0, 5'd5, 5'd6, 0, 0);
    #1 chk("hazard_stall", stall, 1);
    tick();
    chk("hazard_ex_bubble", {ex_reg_dst, ex_alu_op}, 0);
    #1 chk("hazard_released", stall, 0);
    tick();
    chk("hazard_r_issued", ex_reg_dst, 1);
    // load to r0 never stalls
    drive(1, 6'd35, 5'd1, 5'd0, 0, 0);
    tick();
    drive(1, 6'd0, 5'd0, 5'd0, 0, 0);
    #1 chk("hazard_r0_no_stall", stall, 0);
    idle(); tick(); tick(); tick();
`endif

    // flush with SW in EX and ADDI in ID
    drive(1, 6'd43, 5'd1, 5'd2, 0, 0);
    tick();
    drive(1, 6'd8, 5'd3, 5'd4, 0, 1);
    tick();
    chk("flush_mem_write", mem_write, 0);
    chk("flush_ex_bubble", {ex_reg_dst, ex_alu_src}, 0);
    idle(); tick(); tick(); tick();

    // illegal opcode 63
    drive(1, 6'd63, 5'd0, 5'd0, 0, 0);
    tick();
    chk("illegal_ex", {ex_illegal, ex_reg_dst, ex_alu_src, ex_alu_op}, 32'h40);
    idle();
    tick();
    chk("illegal_one_cycle", ex_illegal, 0);
    chk("illegal_mem_zero", {mem_branch, mem_read, mem_write}, 0);
    tick();
    chk("illegal_wb_zero", {wb_reg_write, wb_mem_to_reg}, 0);

    // ext_stall with flush, then SLTI on the 6-bit instance
    drive(1, 6'd8, 5'd1, 5'd2, 1, 1);
    #1 chk("stall_flush_stall", stall, 1);
    tick();
    chk("stall_flush_bubble", {ex_alu_src, ex_reg_dst}, 0);
    drive(1, 6'd10, 5'd1, 5'd2, 0, 0);
    tick();
    chk("slti_alu_op6", ex_alu_op6, 6'b000101);
    idle(); tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, rand_ops[$urandom_range(0, 9)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b1;
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL have parameter ALU_OP_W, default 4, ALU operation code width (legal values are 4 or more).
REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, register specifier width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have port id_valid, input, 1 bit, an instruction is present in ID this cycle.
REQ-006 The block SHALL have port id_opcode, input, 6 bits, opcode of the ID instruction.
REQ-007 The block SHALL have ports id_rs and id_rt, inputs, REG_ADDR_W bits each, source specifiers of the ID instruction.
REQ-008 The block SHALL have port ext_stall, input, 1 bit, external stall request.
REQ-009 The block SHALL have port flush, input, 1 bit, branch-taken kill request.
REQ-010 The block SHALL have port stall, output, 1 bit, hold IF/ID request to upstream.
REQ-011 The block SHALL have EX-stage outputs ex_reg_dst (1 bit), ex_alu_src (1 bit), ex_alu_op (ALU_OP_W bits) and ex_illegal (1 bit).
REQ-012 The block SHALL have MEM-stage outputs mem_branch, mem_read and mem_write, each 1 bit.
REQ-013 The block SHALL have WB-stage outputs wb_reg_write and wb_mem_to_reg, each 1 bit.

Function
REQ-014 The block SHALL decode id_opcode combinationally into a bundle {reg_dst, alu_src, alu_op, branch, mem_read, mem_write, reg_write, mem_to_reg, illegal}.
REQ-015 The decode table SHALL be: R-type (0) = reg_dst 1, alu_op 0010, reg_write 1; LW (35) = alu_src 1, alu_op 0000, mem_read 1, reg_write 1, mem_to_reg 1; SW (43) = alu_src 1, alu_op 0000, mem_write 1; BEQ (4) = alu_op 0001, branch 1; ADDI (8) = alu_src 1, alu_op 0000, reg_write 1; ANDI (12) = alu_src 1, alu_op 0011, reg_write 1; ORI (13) = alu_src 1, alu_op 0100, reg_write 1; SLTI (10) = alu_src 1, alu_op 0101, reg_write 1; every unnamed field is 0.
REQ-016 Any other opcode SHALL decode to an all-zero bundle with illegal=1.
REQ-017 The 4-bit alu_op codes SHALL be zero-extended to ALU_OP_W.
REQ-018 The block SHALL register the bundle through ID/EX, EX/MEM and MEM/WB stages, giving latency 1, 2 and 3 cycles to the EX, MEM and WB outputs respectively.
REQ-019 A stage holding no valid instruction (bubble) SHALL drive all of its outputs to 0.
REQ-020 The ID/EX register SHALL load a bubble when id_valid=0, stall=1 or flush=1; otherwise it SHALL load the decoded bundle together with id_rt.
REQ-021 When flush=1, the content of EX SHALL advance to MEM as a bubble; MEM and WB content SHALL be unaffected.
REQ-022 EX/MEM and MEM/WB SHALL advance every cycle; stall SHALL insert a bubble only and never freeze the downstream stages.
REQ-023 The stall output SHALL equal ext_stall OR hazard, combinationally.
REQ-024 When flush and stall are both 1, flush SHALL take precedence; stall is still driven out unchanged.
REQ-025 An illegal opcode SHALL propagate as a bubble for all control fields, with ex_illegal=1 for one cycle in EX.

Reset
REQ-026 While reset=0 at a rising clk edge, all pipeline stages SHALL be loaded with bubbles, so every registered output is 0 in the following cycle.
REQ-027 Reset SHALL override flush, stall and id_valid; an instruction in flight during reset SHALL be discarded.
REQ-028 In the first cycle after reset deasserts, decoding SHALL resume normally.

Configuration
REQ-029 With macro PIPE_CTRL_HAZARD_DETECT_EN defined, hazard SHALL be 1 when EX is valid with mem_read=1, ex_rt!=0, and either ex_rt==id_rs, or ex_rt==id_rt with the ID opcode R-type, SW or BEQ, and id_valid=1.
REQ-030 Without the macro, hazard SHALL be constant 0, stall SHALL equal ext_stall, and no ex_rt storage SHALL be synthesised.

Verification
REQ-031 Bench SHALL check: reset low for 2 cycles with id_valid=1 and opcode 35 -> all outputs 0; after release, LW gives ex_alu_src=1 at +1, mem_read=1 at +2, wb_mem_to_reg=1 at +3.
REQ-032 Bench SHALL check: the sequence R, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI back-to-back -> ex_alu_op reads 0010, 0000, 0000, 0001, 0000, 0011, 0100, 0101 on consecutive cycles.
REQ-033 Bench SHALL check (with the macro): LW with rt=5, then R-type with rs=5 -> stall=1 for one cycle and an EX bubble; with rt=0, no stall.
REQ-034 Bench SHALL check: flush=1 while SW is in EX and ADDI is in ID -> mem_write stays 0 and ex_reg_dst and ex_alu_src are 0 in the next cycle.
REQ-035 Bench SHALL check: opcode 63 -> ex_illegal=1 for one cycle, with all control outputs 0 in every stage.
REQ-036 Bench SHALL check: ext_stall=1 together with flush=1 -> stall=1 and a bubble enters EX; ALU_OP_W=6 gives SLTI ex_alu_op=000101.
